// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word per instruction over req/ready,
// and retires it by selecting the next PC from jump/branch/zero.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump
);

    // state | meaning
    // IDLE  | one-cycle bubble after reset, no request
    // FETCH | request at pc outstanding until imem_ready
    // HOLD  | instruction valid, retires on the first cycle with stall=0
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FETCH = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;

    logic [31:0] pc_plus4_w;
    logic [31:0] branch_off;
    logic [31:0] jump_tgt;
    logic [31:0] next_pc;

    assign pc_plus4_w = pc_q + 32'd4;
    assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign jump_tgt   = {pc_plus4_w[31:28], instr_q[25:0], 2'b00};

    // Jump wins over a taken branch; all sums wrap modulo 2^32.
    always_comb begin
        next_pc = pc_plus4_w;
        if (jump) begin
            next_pc = jump_tgt;
        end else if (branch && zero) begin
            next_pc = pc_plus4_w + branch_off;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    pc_d          = next_pc;
                    instr_valid_d = 1'b0;
                    state_d       = ST_FETCH;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_plus4_w;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: walks one program through linear fetch,
// wait states, branches, jumps, stall with PC wrap, and asynchronous reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;

    int vectors     = 0;
    int miscompares = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are observed on the falling edge.
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // From FETCH: return word w at once, then retire it with the given controls.
    task automatic run_instr(input logic [31:0] w, input logic br, input logic z, input logic j);
        imem_ready = 1'b1; imem_rdata = w; stall = 1'b0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0;
        step();
        branch = br; zero = z; jump = j;
        step();
        branch = 1'b0; zero = 1'b0; jump = 1'b0; imem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        branch = 1'b0; zero = 1'b0; jump = 1'b0;
        step(2);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %h want 0", imem_req); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %h want 0", instr_valid); end
        vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", pc); end
        vectors++; if (pc_plus4 !== 32'h4) begin miscompares++; $display("FAIL reset_pc_plus4: got %h want 4", pc_plus4); end
        vectors++; if (instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", instr); end
        vectors++; if (opcode !== 6'h0) begin miscompares++; $display("FAIL reset_opcode: got %h want 0", opcode); end
        rst_n = 1'b1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL idle_req: got %h want 0", imem_req); end
        step();
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req: got %h want 1", imem_req); end
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_linear_fetch();
        imem_ready = 1'b1; stall = 1'b0; imem_rdata = 32'h8C01_0004;
        step();
        vectors++; if (instr_valid !== 1'b1) begin miscompares++; $display("FAIL lin0_valid: got %h want 1", instr_valid); end
        vectors++; if (instr !== 32'h8C01_0004) begin miscompares++; $display("FAIL lin0_instr: got %h want 8c010004", instr); end
        vectors++; if (opcode !== 6'h23) begin miscompares++; $display("FAIL lin0_opcode: got %h want 23", opcode); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL lin0_hold_req: got %h want 0", imem_req); end
        imem_rdata = 32'h0022_1820;
        step();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin miscompares++; $display("FAIL lin1_addr: got req=%h addr=%h want req=1 addr=4", imem_req, imem_addr); end
        vectors++; if (instr_valid !== 1'b0) begin miscompares++; $display("FAIL lin1_valid_low: got %h want 0", instr_valid); end
        vectors++; if (pc_plus4 !== 32'h8) begin miscompares++; $display("FAIL lin1_pc_plus4: got %h want 8", pc_plus4); end
        step();
        vectors++; if (instr_valid !== 1'b1 || opcode !== 6'h00) begin miscompares++; $display("FAIL lin1_capture: got valid=%h op=%h want valid=1 op=00", instr_valid, opcode); end
        imem_rdata = 32'h0800_0004;
        step();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL lin2_addr: got req=%h addr=%h want req=1 addr=8", imem_req, imem_addr); end
        step();
        vectors++; if (instr !== 32'h0800_0004 || opcode !== 6'h02) begin miscompares++; $display("FAIL lin2_capture: got instr=%h op=%h want 08000004/02", instr, opcode); end
        jump = 1'b1; imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        step();
        jump = 1'b0;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin miscompares++; $display("FAIL jump_0x10: got req=%h addr=%h want req=1 addr=10", imem_req, imem_addr); end
    endtask

    task automatic test_wait_states();
        for (int i = 0; i < 3; i++) begin
            vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL wait%0d: got req=%h addr=%h valid=%h want 1/10/0", i, imem_req, imem_addr, instr_valid); end
            vectors++; if (instr !== 32'h0800_0004) begin miscompares++; $display("FAIL wait%0d_instr: got %h want 08000004", i, instr); end
            step();
        end
        imem_ready = 1'b1; imem_rdata = 32'h0800_0040;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin miscompares++; $display("FAIL wait_ready_cycle: got req=%h addr=%h want 1/10", imem_req, imem_addr); end
        step();
        imem_ready = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        vectors++; if (instr_valid !== 1'b1 || instr !== 32'h0800_0040) begin miscompares++; $display("FAIL wait_capture: got valid=%h instr=%h want 1/08000040", instr_valid, instr); end
        jump = 1'b1;
        step();
        jump = 1'b0;
        vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL jump_0x100: got %h want 100", imem_addr); end
    endtask

    task automatic test_branch();
        run_instr(32'h1000_FFFE, 1'b1, 1'b1, 1'b0);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0FC) begin miscompares++; $display("FAIL br_taken: got req=%h addr=%h want 1/fc", imem_req, imem_addr); end
        run_instr(32'h0800_0040, 1'b0, 1'b0, 1'b1);
        vectors++; if (imem_addr !== 32'h100) begin miscompares++; $display("FAIL back_to_0x100: got %h want 100", imem_addr); end
        run_instr(32'h1000_FFFE, 1'b1, 1'b0, 1'b0);
        vectors++; if (imem_addr !== 32'h104) begin miscompares++; $display("FAIL br_not_taken: got %h want 104", imem_addr); end
        run_instr(32'h0800_0000, 1'b0, 1'b0, 1'b1);
        vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL jump_0: got %h want 0", imem_addr); end
        run_instr(32'h1000_FFFE, 1'b1, 1'b1, 1'b0);
        vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL br_neg_wrap: got %h want fffffffc", imem_addr); end
    endtask

    task automatic test_stall_wrap();
        imem_ready = 1'b1; imem_rdata = 32'h8C22_0000; stall = 1'b1;
        step();
        imem_ready = 1'b0;
        vectors++; if (instr_valid !== 1'b1 || pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL wrap_pc_plus4: got valid=%h pc4=%h want 1/0", instr_valid, pc_plus4); end
        for (int i = 0; i < 5; i++) begin
            branch = i[0]; jump = ~i[0]; zero = 1'b1; imem_rdata = 32'h1234_0000 + i;
            step();
            vectors++; if (instr_valid !== 1'b1 || instr !== 32'h8C22_0000 || pc !== 32'hFFFF_FFFC || imem_req !== 1'b0) begin miscompares++; $display("FAIL stall%0d: got valid=%h instr=%h pc=%h req=%h want 1/8c220000/fffffffc/0", i, instr_valid, instr, pc, imem_req); end
        end
        stall = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
        step();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin miscompares++; $display("FAIL stall_release: got req=%h addr=%h valid=%h want 1/0/0", imem_req, imem_addr, instr_valid); end
    endtask

    task automatic test_jump_priority();
        run_instr(32'h0BFF_FFFF, 1'b0, 1'b0, 1'b1);
        vectors++; if (imem_addr !== 32'h0FFF_FFFC) begin miscompares++; $display("FAIL jump_max: got %h want 0ffffffc", imem_addr); end
        run_instr(32'h0800_0000, 1'b0, 1'b0, 1'b1);
        vectors++; if (imem_addr !== 32'h1000_0000) begin miscompares++; $display("FAIL jump_region: got %h want 10000000", imem_addr); end
        run_instr(32'h0800_0040, 1'b1, 1'b1, 1'b1);
        vectors++; if (imem_addr !== 32'h1000_0100) begin miscompares++; $display("FAIL jump_priority: got %h want 10000100", imem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        run_instr(32'h0800_0008, 1'b0, 1'b0, 1'b1);
        step();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin miscompares++; $display("FAIL pre_abort_fetch: got req=%h addr=%h want 1/20", imem_req, imem_addr); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0) begin miscompares++; $display("FAIL abort_fetch: got req=%h valid=%h pc=%h want 0/0/0", imem_req, instr_valid, pc); end
        step();
        rst_n = 1'b1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got %h want 0", imem_req); end
        step();
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL restart_addr: got req=%h addr=%h want 1/0", imem_req, imem_addr); end
        imem_ready = 1'b1; imem_rdata = 32'hAC03_0008; stall = 1'b1;
        step();
        imem_ready = 1'b0;
        vectors++; if (instr_valid !== 1'b1 || instr !== 32'hAC03_0008) begin miscompares++; $display("FAIL restart_capture: got valid=%h instr=%h want 1/ac030008", instr_valid, instr); end
        #2 rst_n = 1'b0;
        #1;
        vectors++; if (instr_valid !== 1'b0 || instr !== 32'h0 || opcode !== 6'h0) begin miscompares++; $display("FAIL abort_hold: got valid=%h instr=%h op=%h want 0/0/0", instr_valid, instr, opcode); end
        step();
        rst_n = 1'b1; stall = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_linear_fetch();
        test_wait_states();
        test_branch();
        test_stall_wrap();
        test_jump_priority();
        test_reset_mid_fetch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
